decode_stage: RTL and testbench

- Instruction-decode stage sitting directly downstream of the fetch stage; consumes its pc/instr pair.
- Holds the IF/ID pipeline register with valid, stall and flush.
- Contains the 32x32 integer register file (with write-through bypass from writeback) and immediate generation.
- Presents decoded fields, register operands and immediate to the execute stage.

---
 rtl/decode_stage_pkg.sv | 44 ++++
 rtl/decode_stage_regfile.sv | 47 ++++
 rtl/decode_stage.sv | 91 +++++++++
 tb/tb_decode_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: RV32I opcodes, the NOP encoding, the immediate kinds and the IF/ID register layout.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  function automatic imm_type_e imm_type_of(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: return IMM_I;
      OPC_STORE:                      return IMM_S;
      OPC_BRANCH:                     return IMM_B;
      OPC_LUI, OPC_AUIPC:             return IMM_U;
      OPC_JAL:                        return IMM_J;
      default:                        return IMM_NONE;
    endcase
  endfunction

  function automatic logic opcode_legal(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_SYSTEM: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Integer register file: 2 combinational reads, 1 synchronous write, x0 hardwired to zero.
// Latency: reads 0 cycles, with same-cycle write-through bypass from writeback.
// Backpressure: none; writes are accepted every cycle regardless of pipeline stalls.
module decode_stage_regfile #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic            wb_hit;

  assign wb_hit = wb_en && (wb_rd != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rs1_addr == '0)                 rs1_data = '0;
    else if (wb_hit && wb_rd == rs1_addr) rs1_data = wb_data;
    else                                rs1_data = regs[rs1_addr];
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr == '0)                 rs2_data = '0;
    else if (wb_hit && wb_rd == rs2_addr) rs2_data = wb_data;
    else                                rs2_data = regs[rs2_addr];
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode: IF/ID register, register file reads and immediate generation for execute.
// Latency: 1 cycle from if_instr to decode outputs; everything after the IF/ID register is combinational.
// Backpressure: stall holds IF/ID, flush inserts a bubble and overrides stall.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          NUM_REGS = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [31:0]     if_pc,
  input  logic [31:0]     if_instr,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_valid,
  output logic [31:0]     id_pc,
  output logic [31:0]     id_instr,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  ifid_t     ifid_q;
  imm_type_e imm_type;
  logic [31:0] ins;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_q <= '{valid: 1'b0, pc: RESET_PC, instr: NOP_INSTR};
    end else if (flush) begin
      ifid_q <= '{valid: 1'b0, pc: if_pc, instr: NOP_INSTR};
    end else if (!stall) begin
      ifid_q <= '{valid: 1'b1, pc: if_pc, instr: if_instr};
    end
  end

  assign id_valid = ifid_q.valid;
  assign id_pc    = ifid_q.pc;
  assign id_instr = ifid_q.instr;
  assign ins      = ifid_q.instr;

  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];
  assign funct7 = ins[31:25];
  assign rs1    = ins[19:15];
  assign rs2    = ins[24:20];
  assign rd     = ins[11:7];

  assign illegal  = id_valid && !opcode_legal(opcode);
  assign imm_type = imm_type_of(opcode);

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:   imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
      IMM_J:   imm = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  decode_stage_regfile #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a decode vector table plus hand-written reset, bypass, x0 and stall/flush sequences.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush;
  logic [31:0] if_pc, if_instr;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        id_valid;
  logic [31:0] id_pc, id_instr;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1_data, rs2_data, imm;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .if_pc(if_pc), .if_instr(if_instr),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //          instr          opc       rd  rs1 rs2 f3 f7      imm            ill
    vecs[0]  = '{32'hFFF0_8093, 7'h13, 1,  1,  31, 0, 7'h7F, 32'hFFFF_FFFF, 1'b0}; // addi x1,x1,-1
    vecs[1]  = '{32'hFE00_0EE3, 7'h63, 29, 0,  0,  0, 7'h7F, 32'hFFFF_FFFC, 1'b0}; // beq -4
    vecs[2]  = '{32'h0080_006F, 7'h6F, 0,  0,  8,  0, 7'h00, 32'h0000_0008, 1'b0}; // jal x0,8
    vecs[3]  = '{32'h0000_0000, 7'h00, 0,  0,  0,  0, 7'h00, 32'h0000_0000, 1'b1};
    vecs[4]  = '{32'hFE11_2E23, 7'h23, 28, 2,  1,  2, 7'h7F, 32'hFFFF_FFFC, 1'b0}; // sw x1,-4(x2)
    vecs[5]  = '{32'h1234_52B7, 7'h37, 5,  8,  3,  5, 7'h09, 32'h1234_5000, 1'b0}; // lui
    vecs[6]  = '{32'h0020_81B3, 7'h33, 3,  1,  2,  0, 7'h00, 32'h0000_0000, 1'b0}; // add
    vecs[7]  = '{32'h0000_000B, 7'h0B, 0,  0,  0,  0, 7'h00, 32'h0000_0000, 1'b1}; // custom-0
    vecs[8]  = '{32'h0000_0073, 7'h73, 0,  0,  0,  0, 7'h00, 32'h0000_0000, 1'b0}; // ecall
    vecs[9]  = '{32'h0081_2083, 7'h03, 1,  2,  8,  2, 7'h00, 32'h0000_0008, 1'b0}; // lw x1,8(x2)
    vecs[10] = '{32'hFFC0_8067, 7'h67, 0,  1,  28, 0, 7'h7F, 32'hFFFF_FFFC, 1'b0}; // jalr -4(x1)
    vecs[11] = '{32'h0000_1117, 7'h17, 2,  0,  0,  1, 7'h00, 32'h0000_1000, 1'b0}; // auipc x2,1

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    if_pc = 32'h0; if_instr = 32'h0000_0013;
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Populate x5, observe it, then reset mid-cycle and confirm it is cleared.
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_AAAA;
    if_pc = 32'h20; if_instr = 32'h0002_8093;  // addi x1,x5,0
    step();
    wb_en = 1'b0;
    check("x5_before_reset", rs1_data, 32'h0000_AAAA);
    check("valid_before_reset", {31'b0, id_valid}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("reset_valid", {31'b0, id_valid}, 32'h0);
    check("reset_instr", id_instr, 32'h0000_0013);
    check("reset_pc", id_pc, 32'h0);
    check("reset_illegal", {31'b0, illegal}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("x5_after_reset", rs1_data, 32'h0);
    check("valid_after_reset_load", {31'b0, id_valid}, 32'h1);

    // Decode table.
    for (int i = 0; i < 12; i++) begin
      if_instr = vecs[i].instr;
      if_pc    = 32'h100 + 32'(i) * 4;
      step();
      check($sformatf("valid[%0d]", i), {31'b0, id_valid}, 32'h1);
      check($sformatf("pc[%0d]", i), id_pc, 32'h100 + 32'(i) * 4);
      check($sformatf("instr[%0d]", i), id_instr, vecs[i].instr);
      check($sformatf("opcode[%0d]", i), {25'b0, opcode}, {25'b0, vecs[i].opc});
      check($sformatf("rd[%0d]", i), {27'b0, rd}, {27'b0, vecs[i].rd});
      check($sformatf("rs1[%0d]", i), {27'b0, rs1}, {27'b0, vecs[i].rs1});
      check($sformatf("rs2[%0d]", i), {27'b0, rs2}, {27'b0, vecs[i].rs2});
      check($sformatf("funct3[%0d]", i), {29'b0, funct3}, {29'b0, vecs[i].f3});
      check($sformatf("funct7[%0d]", i), {25'b0, funct7}, {25'b0, vecs[i].f7});
      check($sformatf("imm[%0d]", i), imm, vecs[i].imm);
      check($sformatf("illegal[%0d]", i), {31'b0, illegal}, {31'b0, vecs[i].ill});
    end

    // Write-through bypass on both read ports; the write lands even while stalled.
    if_instr = 32'h0031_80B3;  // add x1,x3,x3
    if_pc    = 32'h300;
    step();
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
    #1;
    check("bypass_rs1", rs1_data, 32'hDEAD_BEEF);
    check("bypass_rs2", rs2_data, 32'hDEAD_BEEF);
    stall = 1'b1;
    step();
    wb_en = 1'b0; wb_data = 32'h0;
    #1;
    check("stored_rs1", rs1_data, 32'hDEAD_BEEF);
    check("stored_rs2", rs2_data, 32'hDEAD_BEEF);
    stall = 1'b0;

    // Writes to x0 are dropped.
    if_instr = 32'h0000_00B3;  // add x1,x0,x0
    if_pc    = 32'h304;
    step();
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_1234;
    #1;
    check("x0_same_cycle_rs1", rs1_data, 32'h0);
    check("x0_same_cycle_rs2", rs2_data, 32'h0);
    step();
    wb_en = 1'b0;
    check("x0_after_rs1", rs1_data, 32'h0);

    // Stall holds IF/ID for three cycles while fetch keeps changing.
    if_instr = 32'h0081_2083;
    if_pc    = 32'h400;
    step();
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if_instr = 32'h0000_1117 + 32'(c);
      if_pc    = 32'h500 + 32'(c) * 4;
      step();
      check($sformatf("stall_instr[%0d]", c), id_instr, 32'h0081_2083);
      check($sformatf("stall_pc[%0d]", c), id_pc, 32'h400);
      check($sformatf("stall_valid[%0d]", c), {31'b0, id_valid}, 32'h1);
    end

    // Flush beats stall: bubble with the fetch pc.
    flush = 1'b1;
    if_instr = 32'h0000_0000;
    if_pc    = 32'h600;
    step();
    check("flush_valid", {31'b0, id_valid}, 32'h0);
    check("flush_instr", id_instr, 32'h0000_0013);
    check("flush_pc", id_pc, 32'h600);
    check("flush_illegal", {31'b0, illegal}, 32'h0);
    flush = 1'b0; stall = 1'b0;
    if_instr = 32'h0000_0000;
    if_pc    = 32'h604;
    step();
    check("post_flush_valid", {31'b0, id_valid}, 32'h1);
    check("post_flush_illegal", {31'b0, illegal}, 32'h1);
    check("post_flush_x3", rs1_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
